// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the single regfile write port among num_req_p writeback sources.
// Port 0 is the core pipeline writeback and has priority. Ports 1..N-1 are long-latency sources
// and are served round-robin among themselves. At most one write is granted per cycle. The
// granted write is held in one output register, so it reaches the regfile one cycle later.
//
// Optional feature: define REGFILE_WB_ARB_STARVE_EN to compile in the starvation counter. The
// counter lets a waiting low-priority port win after starve_limit_p consecutive port-0 grants.
// With the macro undefined, port 0 has strict priority and starve_limit_p is ignored.
//
// Ports:
//   clk_i        clock, rising edge
//   reset_n_i    asynchronous active-low reset
//   req_v_i      per-requester write valid
//   req_addr_i   per-requester destination register
//   req_data_i   per-requester write data
//   req_ready_o  grant, one-hot or zero, combinational
//   w_v_o        regfile write enable (registered)
//   w_addr_o     regfile write address (registered)
//   w_data_o     regfile write data (registered)
module regfile_wb_arbiter #(
  parameter int unsigned width_p           = 32,
  parameter int unsigned els_p             = 32,
  parameter int unsigned num_req_p         = 4,
  parameter int unsigned starve_limit_p    = 4,
  parameter bit          x0_tied_to_zero_p = 1'b0,
  localparam int unsigned addr_width_lp    = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                                    clk_i,
  input  logic                                    reset_n_i,
  input  logic [num_req_p-1:0]                    req_v_i,
  input  logic [num_req_p-1:0][addr_width_lp-1:0] req_addr_i,
  input  logic [num_req_p-1:0][width_p-1:0]       req_data_i,
  output logic [num_req_p-1:0]                    req_ready_o,
  output logic                                    w_v_o,
  output logic [addr_width_lp-1:0]                w_addr_o,
  output logic [width_p-1:0]                      w_data_o
);

  localparam int unsigned IdxWidth = $clog2(num_req_p);

  // Candidate port for search step `step`, starting after `last` and wrapping N-1 -> 1.
  // last is always in 1..N-1, so the subtraction cannot underflow.
  function automatic logic [IdxWidth-1:0] rr_cand(input logic [IdxWidth-1:0] last,
                                                 input int unsigned step);
    int unsigned pos;
    pos = ((32'(last) - 1 + step) % (num_req_p - 1)) + 1;
    return pos[IdxWidth-1:0];
  endfunction

  logic [IdxWidth-1:0]      last_r, last_d, rr_idx, sel_idx;
  logic                     rr_found, lp_any, lp_gnt, starve_hit, xfer;
  logic [num_req_p-1:0]     gnt;
  logic [addr_width_lp-1:0] gnt_addr;
  logic [width_p-1:0]       gnt_data;

`ifdef REGFILE_WB_ARB_STARVE_EN
  localparam int unsigned CntWidth = $clog2(starve_limit_p + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(starve_limit_p);

  logic [CntWidth-1:0] starve_cnt_r, starve_cnt_d;

  assign starve_hit = (starve_cnt_r == CntMax) && lp_any;

  always_comb begin
    starve_cnt_d = starve_cnt_r;
    if (lp_gnt || !lp_any) begin
      starve_cnt_d = '0;
    end else if (gnt[0] && (starve_cnt_r != CntMax)) begin
      starve_cnt_d = starve_cnt_r + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      starve_cnt_r <= '0;
    end else begin
      starve_cnt_r <= starve_cnt_d;
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  assign lp_any = |req_v_i[num_req_p-1:1];

  always_comb begin
    rr_found = 1'b0;
    rr_idx   = last_r;
    for (int unsigned i = 1; i < num_req_p; i++) begin
      if (!rr_found && req_v_i[rr_cand(last_r, i)]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand(last_r, i);
      end
    end
  end

  // Grants are suppressed while reset is asserted so ready reads zero during reset.
  always_comb begin
    gnt    = '0;
    lp_gnt = 1'b0;
    if (reset_n_i) begin
      if (rr_found && (starve_hit || !req_v_i[0])) begin
        gnt[rr_idx] = 1'b1;
        lp_gnt      = 1'b1;
      end else if (req_v_i[0]) begin
        gnt[0] = 1'b1;
      end
    end
  end

  assign req_ready_o = gnt;
  assign xfer        = |gnt;
  assign sel_idx     = lp_gnt ? rr_idx : '0;
  assign gnt_addr    = req_addr_i[sel_idx];
  assign gnt_data    = req_data_i[sel_idx];
  assign last_d      = lp_gnt ? rr_idx : last_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      w_v_o    <= 1'b0;
      w_addr_o <= '0;
      w_data_o <= '0;
      last_r   <= IdxWidth'(num_req_p - 1);
    end else begin
      // Writes to x0 are accepted but never reach the regfile when it is hardwired to zero.
      w_v_o  <= xfer && !(x0_tied_to_zero_p && (gnt_addr == '0));
      last_r <= last_d;
      if (xfer) begin
        w_addr_o <= gnt_addr;
        w_data_o <= gnt_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (3 requesters, 16-bit data, 32 regs).
// dut_a has x0 writable; dut_b has x0 tied to zero and shares all inputs with dut_a.
// A small regfile model commits dut_a writes to check ordering and reset behaviour.
module tb_regfile_wb_arbiter;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [2:0]      req_v;
  logic [2:0][4:0] req_addr;
  logic [2:0][15:0] req_data;
  logic [2:0]      ready_a, ready_b;
  logic            w_v_a, w_v_b;
  logic [4:0]      w_addr_a, w_addr_b;
  logic [15:0]     w_data_a, w_data_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] rf [32];

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .width_p(16), .els_p(32), .num_req_p(3), .starve_limit_p(4), .x0_tied_to_zero_p(1'b0)
  ) dut_a (
    .clk_i(clk), .reset_n_i(reset_n), .req_v_i(req_v), .req_addr_i(req_addr),
    .req_data_i(req_data), .req_ready_o(ready_a), .w_v_o(w_v_a), .w_addr_o(w_addr_a),
    .w_data_o(w_data_a)
  );

  regfile_wb_arbiter #(
    .width_p(16), .els_p(32), .num_req_p(3), .starve_limit_p(4), .x0_tied_to_zero_p(1'b1)
  ) dut_b (
    .clk_i(clk), .reset_n_i(reset_n), .req_v_i(req_v), .req_addr_i(req_addr),
    .req_data_i(req_data), .req_ready_o(ready_b), .w_v_o(w_v_b), .w_addr_o(w_addr_b),
    .w_data_o(w_data_b)
  );

  // Regfile model: commits on the edge where the write port is valid.
  always @(posedge clk) begin
    if (w_v_a) rf[w_addr_a] <= w_data_a;
  end

  // Protocol monitor: a pending request must hold valid/addr/data until it transfers.
  logic [2:0]       pend;
  logic [2:0][4:0]  pend_addr;
  logic [2:0][15:0] pend_data;
  always @(posedge clk) begin
    if (reset_n) begin
      for (int k = 0; k < 3; k++) begin
        if (pend[k]) begin
          assert (req_v[k] && req_addr[k] == pend_addr[k] && req_data[k] == pend_data[k])
            else $error("protocol: port %0d changed before transfer", k);
        end
      end
    end
    pend      <= reset_n ? (req_v & ~ready_a) : 3'b000;
    pend_addr <= req_addr;
    pend_data <= req_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drops all requests together with reset so no pending request is abandoned.
  task automatic do_reset();
    req_v   = 3'b000;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 16'h0000;
    reset_n  = 1'b0;
    req_v    = 3'b111;
    req_addr = '0;
    req_data = '0;
    req_addr[0] = 5'd6; req_data[0] = 16'h0606;
    req_addr[1] = 5'd1; req_data[1] = 16'h0101;
    req_addr[2] = 5'd2; req_data[2] = 16'h0202;

    // Reset held with every request valid.
    tick(); tick();
    check("rst_ready", ready_a, 3'b000);
    check("rst_w_v", w_v_a, 1'b0);
    check("rst_w_addr", w_addr_a, 5'd0);
    check("rst_w_data", w_data_a, 16'h0000);
    reset_n = 1'b1;
    #1;
    check("rel_ready", ready_a, 3'b001);
    tick();
    check("rel_w_v", w_v_a, 1'b1);
    check("rel_w_addr", w_addr_a, 5'd6);
    check("rel_w_data", w_data_a, 16'h0606);
    do_reset();

    // Round-robin among ports 1 and 2 with port 0 idle.
    req_v = 3'b110;
    req_addr[1] = 5'd3; req_data[1] = 16'h1111;
    req_addr[2] = 5'd4; req_data[2] = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr_ready_%0d", i), ready_a, (i % 2 == 0) ? 3'b010 : 3'b100);
      tick();
      check($sformatf("rr_w_v_%0d", i), w_v_a, 1'b1);
      check($sformatf("rr_w_addr_%0d", i), w_addr_a, (i % 2 == 0) ? 5'd3 : 5'd4);
      check($sformatf("rr_w_data_%0d", i), w_data_a, (i % 2 == 0) ? 16'h1111 : 16'h2222);
    end
    do_reset();

    // Port 0 and port 1 both valid continuously.
    req_v = 3'b011;
    req_addr[0] = 5'd1; req_data[0] = 16'h00A0;
    req_addr[1] = 5'd2; req_data[1] = 16'h00B1;
    for (int i = 0; i < 10; i++) begin
      #1;
`ifdef REGFILE_WB_ARB_STARVE_EN
      check($sformatf("starve_ready_%0d", i), ready_a, (i % 5 == 4) ? 3'b010 : 3'b001);
`else
      check($sformatf("strict_ready_%0d", i), ready_a, 3'b001);
`endif
      tick();
    end
    do_reset();

    // Write to x0 from port 1.
    req_v = 3'b010;
    req_addr[1] = 5'd0; req_data[1] = 16'hDEAD;
    #1;
    check("x0_ready_b", ready_b, 3'b010);
    check("x0_ready_a", ready_a, 3'b010);
    tick();
    req_v = 3'b000;
    check("x0_tied_w_v", w_v_b, 1'b0);
    check("x0_open_w_v", w_v_a, 1'b1);
    check("x0_open_w_addr", w_addr_a, 5'd0);
    check("x0_open_w_data", w_data_a, 16'hDEAD);
    tick();
    check("x0_tied_w_v_next", w_v_b, 1'b0);
    check("idle_w_v", w_v_a, 1'b0);
    check("idle_w_data_hold", w_data_a, 16'hDEAD);

    // Same-address writes from port 0 and port 2.
    req_v = 3'b101;
    req_addr[0] = 5'd5; req_data[0] = 16'h0011;
    req_addr[2] = 5'd5; req_data[2] = 16'h0022;
    #1;
    check("same_ready0", ready_a, 3'b001);
    tick();
    req_v = 3'b100;
    check("same_w_data0", w_data_a, 16'h0011);
    #1;
    check("same_ready2", ready_a, 3'b100);
    tick();
    req_v = 3'b000;
    check("same_w_data2", w_data_a, 16'h0022);
    check("same_rf_first", rf[5], 16'h0011);
    tick();
    check("same_rf_final", rf[5], 16'h0022);

    // Async reset while a write to r7 sits in the output register.
    req_v = 3'b010;
    req_addr[1] = 5'd9; req_data[1] = 16'h0099;
    #1;
    check("mid_ready1", ready_a, 3'b010);
    tick();
    req_v = 3'b001;
    req_addr[0] = 5'd7; req_data[0] = 16'h0077;
    #1;
    check("mid_ready0", ready_a, 3'b001);
    tick();
    req_v = 3'b000;
    check("mid_w_v", w_v_a, 1'b1);
    check("mid_w_addr", w_addr_a, 5'd7);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_async_w_v", w_v_a, 1'b0);
    check("mid_async_w_addr", w_addr_a, 5'd0);
    tick();
    check("mid_rf7", rf[7], 16'h0000);
    reset_n = 1'b1;
    req_v = 3'b110;
    req_addr[1] = 5'd10; req_data[1] = 16'h00AA;
    req_addr[2] = 5'd11; req_data[2] = 16'h00BB;
    #1;
    check("mid_last_reset", ready_a, 3'b010);
    tick();
    check("mid_post_w_addr", w_addr_a, 5'd10);
    do_reset();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
